dsp_voice_mixer: RTL and testbench

- Downstream of the per-voice decoders. Consumes every voice's 16-bit signed sample and applies per-voice stereo volume.
- Accumulates all voices into left/right busses, then applies master volume with saturation.
- Owns the output sample-rate timebase. Issues the broadcast advance_trigger that steps every voice decoder to its next output sample.
- Time-multiplexed: one voice per clock through a single shared multiply/accumulate path.

---
 rtl/dsp_voice_mixer.sv | 149 ++++++++++++++
 tb/tb_dsp_voice_mixer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dsp_voice_mixer.sv
// Time-multiplexed stereo voice mixer: one voice per clock through a shared MAC,
// master volume with saturation, and the output sample-rate timebase for the decoders.
module dsp_voice_mixer #(
    parameter int NUM_VOICES        = 8,
    parameter int CLOCKS_PER_SAMPLE = 768
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [16*NUM_VOICES-1:0]  voice_samples,
    input  logic [NUM_VOICES-1:0]     voice_mute,
    input  logic [8*NUM_VOICES-1:0]   voice_volume_left,
    input  logic [8*NUM_VOICES-1:0]   voice_volume_right,
    input  logic [7:0]                master_volume_left,
    input  logic [7:0]                master_volume_right,
    output logic                      advance_trigger,
    output logic [15:0]               sample_left,
    output logic [15:0]               sample_right,
    output logic                      sample_valid,
    output logic                      busy
);

    localparam int CNT_W = $clog2(CLOCKS_PER_SAMPLE);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CLOCKS_PER_SAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, MASTER, OUTPUT} state_t;

    function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
        if (v > 24'sd32767)
            return 16'sh7fff;
        else if (v < -24'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    state_t state_q, state_d;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             start;
    logic [IDX_W-1:0] idx;

    logic [16*NUM_VOICES-1:0] samples_p0;
    logic [NUM_VOICES-1:0]    mute_p0;
    logic [8*NUM_VOICES-1:0]  vol_l_p0;
    logic [8*NUM_VOICES-1:0]  vol_r_p0;
    logic signed [23:0]       acc_l_p1, acc_r_p1;

    logic signed [15:0] cur_s;
    logic signed [7:0]  cur_vl, cur_vr;
    logic signed [23:0] prod_l, prod_r;
    logic signed [7:0]  mvol_l, mvol_r;
    logic signed [15:0] clamp_l, clamp_r;
    logic signed [23:0] mprod_l, mprod_r;
    logic signed [15:0] pend_l, pend_r;

    assign tick  = (tick_cnt == TICK_LAST);
    assign start = (state_q == IDLE) && tick && enable;
    assign busy  = (state_q != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (idx == IDX_LAST) state_d = MASTER;
            MASTER:  state_d = OUTPUT;
            OUTPUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0 -> p1: select the current voice from the snapshot and form both products
    always_comb begin
        cur_s  = samples_p0[{idx, 4'b0000} +: 16];
        cur_vl = vol_l_p0[{idx, 3'b000} +: 8];
        cur_vr = vol_r_p0[{idx, 3'b000} +: 8];
        if (mute_p0[idx])
            cur_s = '0;
    end

    assign prod_l = 24'(cur_s) * 24'(cur_vl);
    assign prod_r = 24'(cur_s) * 24'(cur_vr);

    // Stage p1 -> output: clamp bus to 16 bits, apply master volume, saturate
    assign mvol_l  = master_volume_left;
    assign mvol_r  = master_volume_right;
    assign clamp_l = sat16(acc_l_p1);
    assign clamp_r = sat16(acc_r_p1);
    assign mprod_l = 24'(clamp_l) * 24'(mvol_l);
    assign mprod_r = 24'(clamp_r) * 24'(mvol_r);
    assign pend_l  = sat16(mprod_l >>> 7);
    assign pend_r  = sat16(mprod_r >>> 7);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            samples_p0      <= '0;
            mute_p0         <= '0;
            vol_l_p0        <= '0;
            vol_r_p0        <= '0;
            acc_l_p1        <= '0;
            acc_r_p1        <= '0;
            idx             <= '0;
            sample_left     <= '0;
            sample_right    <= '0;
            sample_valid    <= 1'b0;
            advance_trigger <= 1'b0;
        end else begin
            if (start) begin
                samples_p0 <= voice_samples;
                mute_p0    <= voice_mute;
                vol_l_p0   <= voice_volume_left;
                vol_r_p0   <= voice_volume_right;
                acc_l_p1   <= '0;
                acc_r_p1   <= '0;
                idx        <= '0;
            end else if (state_q == ACCUM) begin
                acc_l_p1 <= acc_l_p1 + (prod_l >>> 6);
                acc_r_p1 <= acc_r_p1 + (prod_r >>> 6);
                idx      <= idx + IDX_W'(1);
            end
            // Outputs land on the edge leaving MASTER so data and pulses share the OUTPUT cycle
            if (state_q == MASTER) begin
                sample_left  <= pend_l;
                sample_right <= pend_r;
            end
            sample_valid    <= (state_q == MASTER);
            advance_trigger <= (state_q == MASTER);
        end
    end

endmodule

// File: tb/tb_dsp_voice_mixer.sv
// Scoreboard bench for dsp_voice_mixer: directed frames with hand-computed mixes,
// a monitor that pops expectations on every output pulse.
module tb_dsp_voice_mixer;

    localparam int NV  = 8;
    localparam int CPS = 32;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic [16*NV-1:0]     voice_samples = '0;
    logic [NV-1:0]        voice_mute = '0;
    logic [8*NV-1:0]      voice_volume_left = '0;
    logic [8*NV-1:0]      voice_volume_right = '0;
    logic [7:0]           master_volume_left = '0;
    logic [7:0]           master_volume_right = '0;
    logic                 advance_trigger;
    logic [15:0]          sample_left;
    logic [15:0]          sample_right;
    logic                 sample_valid;
    logic                 busy;

    dsp_voice_mixer #(.NUM_VOICES(NV), .CLOCKS_PER_SAMPLE(CPS)) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .voice_samples      (voice_samples),
        .voice_mute         (voice_mute),
        .voice_volume_left  (voice_volume_left),
        .voice_volume_right (voice_volume_right),
        .master_volume_left (master_volume_left),
        .master_volume_right(master_volume_right),
        .advance_trigger    (advance_trigger),
        .sample_left        (sample_left),
        .sample_right       (sample_right),
        .sample_valid       (sample_valid),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                 cyc;
        logic signed [15:0] l;
        logic signed [15:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;

    // Cycles since reset release; cycle 0 is the one in which release happens
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (reset && (sample_valid || advance_trigger)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("valid_cycle", cyc, mon_e.cyc);
                check("left", int'($signed(sample_left)), int'(mon_e.l));
                check("right", int'($signed(sample_right)), int'(mon_e.r));
                check("adv_with_valid", int'(advance_trigger), int'(sample_valid));
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    function automatic int next_tick(input int c);
        int t;
        t = CPS - 1;
        while (t < c) t += CPS;
        return t;
    endfunction

    task automatic set_voice(input int i, input logic signed [15:0] s,
                             input logic signed [7:0] vl, input logic signed [7:0] vr,
                             input logic m);
        voice_samples[16*i +: 16]    = s;
        voice_volume_left[8*i +: 8]  = vl;
        voice_volume_right[8*i +: 8] = vr;
        voice_mute[i]                = m;
    endtask

    // Muted voices carry nonzero garbage so a broken mute shows up
    task automatic only_voices_muted_garbage();
        for (int i = 0; i < NV; i++)
            set_voice(i, 16'sd12345, 8'sd100, -8'sd77, 1'b1);
    endtask

    task automatic set_saturation_case();
        for (int i = 0; i < NV; i++)
            set_voice(i, 16'sd32767, 8'sd127, -8'sd128, 1'b0);
        master_volume_left  = 8'sd127;
        master_volume_right = -8'sd128;
    endtask

    task automatic frame(input logic signed [15:0] el, input logic signed [15:0] er,
                         input bit drop_en);
        int t;
        t = next_tick(cyc);
        enable = 1'b1;
        sb.push_back('{t + NV + 2, el, er});
        wait_cyc(t + 1);
        check("busy_in_frame", int'(busy), 1);
        if (drop_en) enable = 1'b0;
        voice_samples      = {$urandom, $urandom, $urandom, $urandom};
        voice_volume_left  = {$urandom, $urandom};
        voice_volume_right = {$urandom, $urandom};
        voice_mute         = 8'($urandom);
        wait_cyc(t + NV + 4);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_left", int'(sample_left), 0);
        check("rst_right", int'(sample_right), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_adv", int'(advance_trigger), 0);
        check("rst_busy", int'(busy), 0);

        // All-zero frames back to back: first pulse in cycle 41, then every 32
        reset  = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            voice_samples = '0; voice_mute = '0;
            voice_volume_left = '0; voice_volume_right = '0;
            master_volume_left = '0; master_volume_right = '0;
            frame(16'sd0, 16'sd0, 1'b0);
        end

        // Single voice, left/right volumes 64/32
        only_voices_muted_garbage();
        set_voice(0, 16'sd1000, 8'sd64, 8'sd32, 1'b0);
        master_volume_left = 8'sd127; master_volume_right = 8'sd127;
        frame(16'sd992, 16'sd496, 1'b0);

        // Floor shift keeps -1 rather than rounding to 0
        only_voices_muted_garbage();
        set_voice(0, -16'sd1, 8'sd1, 8'sd1, 1'b0);
        master_volume_left = 8'sd127; master_volume_right = 8'sd127;
        frame(-16'sd1, -16'sd1, 1'b0);

        // Bus clamp both directions, then master saturation on the right
        set_saturation_case();
        frame(16'sd32511, 16'sd32767, 1'b0);

        // Two voices with mixed signs; enable dropped during ACCUM
        only_voices_muted_garbage();
        set_voice(1, -16'sd2000, -8'sd64, 8'sd100, 1'b0);
        set_voice(2, 16'sd300, 8'sd10, -8'sd10, 1'b0);
        master_volume_left = 8'sd64; master_volume_right = -8'sd64;
        frame(16'sd1023, 16'sd1586, 1'b1);

        // Disabled across two ticks: no pulses, outputs hold
        master_volume_left = 8'sd127; master_volume_right = 8'sd127;
        wait_cyc(cyc + 2 * CPS + 2);
        check("hold_left", int'($signed(sample_left)), 1023);
        check("hold_right", int'($signed(sample_right)), 1586);
        only_voices_muted_garbage();
        set_voice(0, 16'sd1000, 8'sd64, 8'sd32, 1'b0);
        frame(16'sd992, 16'sd496, 1'b0);

        // Reset in the middle of ACCUM abandons the frame
        set_saturation_case();
        enable = 1'b1;
        begin
            int t;
            t = next_tick(cyc);
            wait_cyc(t + 4);
        end
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_left", int'(sample_left), 0);
        check("midrst_right", int'(sample_right), 0);
        check("midrst_valid", int'(sample_valid), 0);
        check("midrst_adv", int'(advance_trigger), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        set_saturation_case();
        frame(16'sd32511, 16'sd32767, 1'b0);

        enable = 1'b0;
        wait_cyc(cyc + 40);
        check("queue_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
